load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255: max cycles waiting for mem_ack before error.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous active-high reset.
REQ-004 SHALL have port start  in  1  request valid; sampled only when busy=0.
REQ-005 SHALL have port alucode  in  6  access type; ALU_LB/LH/LW/LBU/LHU/SB/SH/SW from the shared define header.
REQ-006 SHALL have port alu_result  in  32  effective byte address from the ALU.
REQ-007 SHALL have port store_data  in  32  rs2 value; low bits used for SB/SH.
REQ-008 SHALL have port busy  out  1  request in flight; start ignored while high.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse.
REQ-010 SHALL have port load_data  out  32  extended load result, valid while done=1.
REQ-011 SHALL have port err  out  1  one-cycle pulse, concurrent with done, on timeout or trapped misalignment.
REQ-012 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32 (word-aligned), mem_be out 4, mem_wdata out 32, mem_ack in 1, mem_rdata in 32.

Function
REQ-013 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-014 IDLE: start=1 with a load/store alucode SHALL latch address, type, lane-shifted wdata, and byte enables, then enter ACCESS next cycle. busy SHALL be 1 from that cycle.
REQ-015 start with a non-memory alucode SHALL be ignored: no state change, no done.
REQ-016 ACCESS SHALL hold mem_req=1 and all mem_* outputs stable until the cycle mem_ack=1 is sampled, then enter RESP.
REQ-017 RESP SHALL pulse done=1 for exactly one cycle, drop busy, and return to IDLE. start is accepted again on the following cycle.
REQ-018 Minimum latency start -> done SHALL be 3 cycles when mem_ack=1 in the first ACCESS cycle.
REQ-019 Loads SHALL capture mem_rdata on the ack cycle, select lane by addr[1:0], and extend as follows: sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW.
REQ-020 Stores SHALL set mem_be to 0001<<addr[1:0] (SB), 0011<<addr[1:0] (SH), or 1111 (SW), and replicate data into the selected lanes. load_data SHALL be 0 for stores.
REQ-021 mem_addr SHALL equal {alu_result[31:2],2'b00}. mem_we SHALL be 1 only for stores.
REQ-022 A wait counter SHALL increment per ACCESS cycle without ack. On reaching ACK_TIMEOUT the FSM SHALL drop mem_req, enter RESP, and assert err with done. A late ack SHALL then be ignored.
REQ-023 mem_ack outside ACCESS SHALL be ignored.

Reset
REQ-024 rst=1 SHALL force IDLE, busy=0, done=0, err=0, load_data=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, and wait counter=0 on the next edge, including mid-ACCESS (the transaction is abandoned with no done).

Configuration
REQ-025 With LSU_MISALIGN_TRAP_EN defined: a halfword at odd address or a word with addr[1:0]!=0 SHALL skip ACCESS (no mem_req), go to RESP, and pulse done+err with load_data=0.
REQ-026 Without LSU_MISALIGN_TRAP_EN: misaligned halfwords SHALL be forced to addr[1]-aligned lanes and words to lane 0, with no err.

Structure
REQ-027 ALU_* access codes and FSM state encodings SHALL live in the shared define header; no local duplicates.
REQ-028 Lane selection/extension and byte-enable/wdata shifting SHALL be one combinational sub-module lsu_align, instantiated once.

Verification
REQ-029 LW at 0x100, mem_rdata=0xDEADBEEF, ack in first ACCESS cycle -> done 3 cycles after start, load_data=0xDEADBEEF, err=0.
REQ-030 LB at 0x103, rdata=0x80FF_FFFF -> load_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
REQ-031 SH at 0x202, store_data=0x1234ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata[31:16]=0xABCD, mem_we=1.
REQ-032 ACK_TIMEOUT=4, mem_ack held 0 -> mem_req drops after 4 ACCESS cycles; done+err pulse together; a later ack is ignored.
REQ-033 LW at 0x102: with trap enabled -> no mem_req, done+err. Without it -> mem_addr=0x100, no err.
REQ-034 rst asserted in the 2nd ACCESS cycle -> next cycle mem_req=0, busy=0, and no done ever pulses for that request.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: ALU access codes, FSM states,
// access-size decoding helpers.
package load_store_unit_pkg;

    localparam logic [5:0] ALU_LB  = 6'h20;
    localparam logic [5:0] ALU_LH  = 6'h21;
    localparam logic [5:0] ALU_LW  = 6'h22;
    localparam logic [5:0] ALU_LBU = 6'h24;
    localparam logic [5:0] ALU_LHU = 6'h25;
    localparam logic [5:0] ALU_SB  = 6'h28;
    localparam logic [5:0] ALU_SH  = 6'h29;
    localparam logic [5:0] ALU_SW  = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_t;

    function automatic logic is_load(input logic [5:0] code);
        return (code == ALU_LB) || (code == ALU_LH) || (code == ALU_LW) ||
               (code == ALU_LBU) || (code == ALU_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] code);
        return (code == ALU_SB) || (code == ALU_SH) || (code == ALU_SW);
    endfunction

    function automatic lsu_size_t size_of(input logic [5:0] code);
        case (code)
            ALU_LB, ALU_LBU, ALU_SB: return SZ_B;
            ALU_LH, ALU_LHU, ALU_SH: return SZ_H;
            default:                 return SZ_W;
        endcase
    endfunction

    function automatic logic is_signed_load(input logic [5:0] code);
        return (code == ALU_LB) || (code == ALU_LH);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit; the LSU drives it as master.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: byte-lane selection for loads (with extension) and lane
// replication / byte-enable generation for stores. Purely combinational.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  lsu_size_t   size,
    input  logic        sign_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ext_data
);

    logic [1:0]  lane;
    logic [31:0] shifted;

    always_comb begin
        lane     = 2'b00;
        be       = 4'b1111;
        wdata    = store_data;
        ext_data = '0;
        // Halfwords snap to the addr[1] lane pair, words to lane 0.
        case (size)
            SZ_B:    lane = addr_lo;
            SZ_H:    lane = {addr_lo[1], 1'b0};
            default: lane = 2'b00;
        endcase
        shifted = rdata >> {lane, 3'b000};
        case (size)
            SZ_B: begin
                be       = 4'b0001 << lane;
                wdata    = {4{store_data[7:0]}};
                ext_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                be       = 4'b0011 << lane;
                wdata    = {2{store_data[15:0]}};
                ext_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be       = 4'b1111;
                wdata    = store_data;
                ext_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding request, IDLE -> ACCESS -> RESP.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [5:0]                alucode,
    input  logic [31:0]               alu_result,
    input  logic [31:0]               store_data,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               load_data,
    output logic                      err,
    load_store_unit_if.master         mem
);

    lsu_state_t  state;
    lsu_size_t   size_q;
    logic        sign_q;
    logic        load_q;
    logic [1:0]  addr_lo_q;
    logic        err_pend;
    logic [31:0] wait_cnt;

    lsu_size_t   al_size;
    logic        al_sign;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ext;
    logic        accept;
    logic        trap;

    // The single aligner serves the incoming request while idle and the
    // latched request while a transaction is in flight.
    always_comb begin
        al_size    = size_q;
        al_sign    = sign_q;
        al_addr_lo = addr_lo_q;
        if (state == ST_IDLE) begin
            al_size    = size_of(alucode);
            al_sign    = is_signed_load(alucode);
            al_addr_lo = alu_result[1:0];
        end
    end

    lsu_align u_align (
        .size       (al_size),
        .sign_ext   (al_sign),
        .addr_lo    (al_addr_lo),
        .store_data (store_data),
        .rdata      (mem.mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .ext_data   (al_ext)
    );

    always_comb begin
        accept = (state == ST_IDLE) && start && (is_load(alucode) || is_store(alucode));
`ifdef LSU_MISALIGN_TRAP_EN
        trap = ((al_size == SZ_H) && alu_result[0]) ||
               ((al_size == SZ_W) && (alu_result[1:0] != 2'b00));
`else
        trap = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            size_q        <= SZ_W;
            sign_q        <= 1'b0;
            load_q        <= 1'b0;
            addr_lo_q     <= '0;
            err_pend      <= 1'b0;
            wait_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            load_data     <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        size_q    <= al_size;
                        sign_q    <= al_sign;
                        load_q    <= is_load(alucode);
                        addr_lo_q <= alu_result[1:0];
                        busy      <= 1'b1;
                        load_data <= '0;
                        wait_cnt  <= '0;
                        if (trap) begin
                            err_pend <= 1'b1;
                            state    <= ST_RESP;
                        end else begin
                            err_pend      <= 1'b0;
                            mem.mem_req   <= 1'b1;
                            mem.mem_we    <= is_store(alucode);
                            mem.mem_addr  <= {alu_result[31:2], 2'b00};
                            mem.mem_be    <= al_be;
                            mem.mem_wdata <= al_wdata;
                            state         <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        if (load_q) begin
                            load_data <= al_ext;
                        end
                        state <= ST_RESP;
                    end else if (wait_cnt == ACK_TIMEOUT - 1) begin
                        mem.mem_req <= 1'b0;
                        err_pend    <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                ST_RESP: begin
                    done     <= 1'b1;
                    err      <= err_pend;
                    err_pend <= 1'b0;
                    busy     <= 1'b0;
                    wait_cnt <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (ACK_TIMEOUT overridden to 4).
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  alucode;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic        err;

    int checks   = 0;
    int failures = 0;

    load_store_unit_if mem_bus ();

    load_store_unit #(.ACK_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .alucode    (alucode),
        .alu_result (alu_result),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .err        (err),
        .mem        (mem_bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns just after the accepting edge.
    task automatic issue(input logic [5:0] code, input logic [31:0] addr, input logic [31:0] sd);
        start      = 1'b1;
        alucode    = code;
        alu_result = addr;
        store_data = sd;
        tick();
        start      = 1'b0;
    endtask

    // Ack in the first ACCESS cycle, then step into the done cycle.
    task automatic ack_now(input logic [31:0] rdata);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = rdata;
        tick();
        mem_bus.mem_ack   = 1'b0;
        tick();
    endtask

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        alucode           = '0;
        alu_result        = '0;
        store_data        = '0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("rst_mem_be", {28'd0, mem_bus.mem_be}, 32'd0);
        chk("rst_mem_addr", mem_bus.mem_addr, 32'd0);

        // LW 0x100: done lands in the third cycle after start.
        issue(ALU_LW, 32'h0000_0100, 32'd0);
        chk("lw_busy", {31'd0, busy}, 32'd1);
        chk("lw_req", {31'd0, mem_bus.mem_req}, 32'd1);
        chk("lw_addr", mem_bus.mem_addr, 32'h0000_0100);
        chk("lw_we", {31'd0, mem_bus.mem_we}, 32'd0);
        chk("lw_be", {28'd0, mem_bus.mem_be}, 32'h0000_000F);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_bus.mem_ack   = 1'b0;
        chk("lw_resp_done", {31'd0, done}, 32'd0);
        chk("lw_resp_req", {31'd0, mem_bus.mem_req}, 32'd0);
        tick();
        chk("lw_done", {31'd0, done}, 32'd1);
        chk("lw_err", {31'd0, err}, 32'd0);
        chk("lw_busy_drop", {31'd0, busy}, 32'd0);
        chk("lw_data", load_data, 32'hDEAD_BEEF);
        tick();
        chk("lw_done_pulse", {31'd0, done}, 32'd0);

        // LB / LBU from lane 3.
        issue(ALU_LB, 32'h0000_0103, 32'd0);
        chk("lb_be", {28'd0, mem_bus.mem_be}, 32'h0000_0008);
        ack_now(32'h80FF_FFFF);
        chk("lb_done", {31'd0, done}, 32'd1);
        chk("lb_data", load_data, 32'hFFFF_FF80);
        tick();
        issue(ALU_LBU, 32'h0000_0103, 32'd0);
        ack_now(32'h80FF_FFFF);
        chk("lbu_done", {31'd0, done}, 32'd1);
        chk("lbu_data", load_data, 32'h0000_0080);
        tick();

        // SH to upper halfword.
        issue(ALU_SH, 32'h0000_0202, 32'h1234_ABCD);
        chk("sh_addr", mem_bus.mem_addr, 32'h0000_0200);
        chk("sh_be", {28'd0, mem_bus.mem_be}, 32'h0000_000C);
        chk("sh_wdata_hi", {16'd0, mem_bus.mem_wdata[31:16]}, 32'h0000_ABCD);
        chk("sh_we", {31'd0, mem_bus.mem_we}, 32'd1);
        ack_now(32'hFFFF_FFFF);
        chk("sh_done", {31'd0, done}, 32'd1);
        chk("sh_load_data", load_data, 32'd0);
        chk("sh_err", {31'd0, err}, 32'd0);
        tick();

        // SB to lane 1.
        issue(ALU_SB, 32'h0000_0101, 32'h0000_0055);
        chk("sb_be", {28'd0, mem_bus.mem_be}, 32'h0000_0002);
        chk("sb_wdata_b1", {24'd0, mem_bus.mem_wdata[15:8]}, 32'h0000_0055);
        ack_now(32'd0);
        chk("sb_done", {31'd0, done}, 32'd1);
        tick();

        // Non-memory code is ignored.
        issue(6'h00, 32'h0000_0100, 32'd0);
        chk("nop_busy", {31'd0, busy}, 32'd0);
        chk("nop_req", {31'd0, mem_bus.mem_req}, 32'd0);
        tick();
        chk("nop_done", {31'd0, done}, 32'd0);

        // Timeout after 4 ACCESS cycles; late ack ignored.
        issue(ALU_LW, 32'h0000_0300, 32'd0);
        chk("to_req_c1", {31'd0, mem_bus.mem_req}, 32'd1);
        tick();
        tick();
        tick();
        chk("to_req_c4", {31'd0, mem_bus.mem_req}, 32'd1);
        tick();
        chk("to_req_drop", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("to_no_done_yet", {31'd0, done}, 32'd0);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("to_done", {31'd0, done}, 32'd1);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_load_data", load_data, 32'd0);
        tick();
        chk("to_late_done", {31'd0, done}, 32'd0);
        chk("to_late_err", {31'd0, err}, 32'd0);
        chk("to_late_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("to_late_busy", {31'd0, busy}, 32'd0);
        mem_bus.mem_ack = 1'b0;

        // Misaligned word at 0x102.
        issue(ALU_LW, 32'h0000_0102, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_trap_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("mis_trap_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("mis_trap_done", {31'd0, done}, 32'd1);
        chk("mis_trap_err", {31'd0, err}, 32'd1);
        chk("mis_trap_data", load_data, 32'd0);
        tick();
`else
        chk("mis_addr", mem_bus.mem_addr, 32'h0000_0100);
        chk("mis_be", {28'd0, mem_bus.mem_be}, 32'h0000_000F);
        ack_now(32'h1122_3344);
        chk("mis_done", {31'd0, done}, 32'd1);
        chk("mis_err", {31'd0, err}, 32'd0);
        chk("mis_data", load_data, 32'h1122_3344);
        tick();
        issue(ALU_LH, 32'h0000_0103, 32'd0);
        chk("mish_be", {28'd0, mem_bus.mem_be}, 32'h0000_000C);
        ack_now(32'h8001_0000);
        chk("mish_data", load_data, 32'hFFFF_8001);
        chk("mish_err", {31'd0, err}, 32'd0);
        tick();
`endif

        // Reset during the 2nd ACCESS cycle abandons the request.
        issue(ALU_SW, 32'h0000_0400, 32'hCAFE_F00D);
        tick();
        chk("rstm_req_before", {31'd0, mem_bus.mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstm_req", {31'd0, mem_bus.mem_req}, 32'd0);
        chk("rstm_busy", {31'd0, busy}, 32'd0);
        chk("rstm_be", {28'd0, mem_bus.mem_be}, 32'd0);
        chk("rstm_addr", mem_bus.mem_addr, 32'd0);
        mem_bus.mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstm_no_done", {31'd0, done}, 32'd0);
        end
        mem_bus.mem_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
